// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle MIPS core: IR opcode and
// memory handshake in, mux selects, write strobes and debug status out.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDST;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       instr_done;
    logic       trap;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDST, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, instr_done, trap
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDST, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, instr_done, trap
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-wait timeout and sticky trap.
// Define MCTRL_PERF_CNT_EN to add cycle_cnt / retired_cnt performance counters.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
`ifdef MCTRL_PERF_CNT_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
`ifdef MCTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retired_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMRD     = 4'd3,
        MEMWB     = 4'd4,
        MEMWR     = 4'd5,
        EXEC      = 4'd6,
        RWB       = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        TRAP      = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    // Moore part of the outputs; the mem_ready-qualified terms are added at the ports.
    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:    c.alu_src_b = 2'b11;
            MEMADR:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:     begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEMWB:     begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
            MEMWR:     begin c.mem_write = 1'b1; c.iord = 1'b1; end
            EXEC:      begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            RWB:       begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
            end
            JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; end
            ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDI_WB:   begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    ctrl_t             ctrl_r;
    logic              trap_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              waiting_s;
    logic              timeout_s;
    logic              fetch_s;

    assign fetch_s   = (state_r == FETCH);
    assign waiting_s = (fetch_s || (state_r == MEMRD) || (state_r == MEMWR)) && !bus.mem_ready;
    assign timeout_s = (TIMEOUT != 0) && waiting_s && (wait_cnt_r == WAIT_LAST);

    // Next-state logic; a ready memory always wins over an expiring timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FETCH: begin
                if (bus.mem_ready)  next_state_s = DECODE;
                else if (timeout_s) next_state_s = TRAP;
                else                next_state_s = FETCH;
            end
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = EXEC;
                    OP_BEQ:       next_state_s = BRANCH;
                    OP_J:         next_state_s = JUMP;
                    OP_ADDI:      next_state_s = ADDI_EXEC;
                    default:      next_state_s = TRAP;
                endcase
            end
            MEMADR: begin
                if (bus.opcode == OP_LW) next_state_s = MEMRD;
                else                     next_state_s = MEMWR;
            end
            MEMRD: begin
                if (bus.mem_ready)  next_state_s = MEMWB;
                else if (timeout_s) next_state_s = TRAP;
                else                next_state_s = MEMRD;
            end
            MEMWR: begin
                if (bus.mem_ready)  next_state_s = FETCH;
                else if (timeout_s) next_state_s = TRAP;
                else                next_state_s = MEMWR;
            end
            MEMWB, RWB, BRANCH, JUMP, ADDI_WB: next_state_s = FETCH;
            EXEC:      next_state_s = RWB;
            ADDI_EXEC: next_state_s = ADDI_WB;
            TRAP:      next_state_s = TRAP;
            default:   next_state_s = TRAP;
        endcase
    end

    // State, sticky trap, wait counter and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= FETCH;
            trap_r     <= 1'b0;
            wait_cnt_r <= '0;
            ctrl_r     <= decode_ctrl(FETCH);
        end else begin
            state_r <= next_state_s;
            trap_r  <= trap_r | (next_state_s == TRAP);
            if ((next_state_s != state_r) || !waiting_s) begin
                wait_cnt_r <= '0;
            end else begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end
            ctrl_r <= decode_ctrl(next_state_s);
        end
    end

    // Strobes are gated by reset so nothing leaks out while it is held.
    assign bus.PCWrite     = !reset && (ctrl_r.pc_write || (fetch_s && bus.mem_ready));
    assign bus.PCWriteCond = !reset && ctrl_r.pc_write_cond;
    assign bus.IorD        = ctrl_r.iord;
    assign bus.MemRead     = !reset && ctrl_r.mem_read;
    assign bus.MemWrite    = !reset && ctrl_r.mem_write;
    assign bus.IRWrite     = !reset && fetch_s && bus.mem_ready;
    assign bus.MemtoReg    = ctrl_r.mem_to_reg;
    assign bus.RegDST      = ctrl_r.reg_dst;
    assign bus.RegWrite    = !reset && ctrl_r.reg_write;
    assign bus.ALUSrcA     = ctrl_r.alu_src_a;
    assign bus.ALUSrcB     = ctrl_r.alu_src_b;
    assign bus.ALUOp       = ctrl_r.alu_op;
    assign bus.PCSource    = ctrl_r.pc_source;
    assign bus.state       = state_r;
    assign bus.instr_done  = !reset && (ctrl_r.instr_done ||
                                        ((state_r == MEMWR) && bus.mem_ready));
    assign bus.trap        = trap_r;

`ifdef MCTRL_PERF_CNT_EN
    // Free-running performance counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state_r != TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (bus.instr_done)  retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle compares the full output
// word {state, strobes, selects, instr_done, trap} against a hand-built vector.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus_if ();

`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;
`endif

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef MCTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    // {state[3:0], PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    //  MemtoReg, RegDST, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, trap}
    logic [21:0] obs;
    assign obs = {bus_if.state, bus_if.PCWrite, bus_if.PCWriteCond, bus_if.IorD,
                  bus_if.MemRead, bus_if.MemWrite, bus_if.IRWrite, bus_if.MemtoReg,
                  bus_if.RegDST, bus_if.RegWrite, bus_if.ALUSrcA, bus_if.ALUSrcB,
                  bus_if.ALUOp, bus_if.PCSource, bus_if.instr_done, bus_if.trap};

    localparam logic [21:0] E_RESET      = {4'd0,  10'b0000000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_FETCH_RDY  = {4'd0,  10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_FETCH_WAIT = {4'd0,  10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_DECODE     = {4'd1,  10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_MEMADR     = {4'd2,  10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_MEMRD      = {4'd3,  10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_MEMRD_RST  = {4'd3,  10'b0010000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_MEMWB      = {4'd4,  10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [21:0] E_MEMWR_WAIT = {4'd5,  10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_MEMWR_RDY  = {4'd5,  10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [21:0] E_EXEC       = {4'd6,  10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_RWB        = {4'd7,  10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [21:0] E_BRANCH     = {4'd8,  10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [21:0] E_JUMP       = {4'd9,  10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [21:0] E_AEXEC      = {4'd10, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [21:0] E_AWB        = {4'd11, 10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [21:0] E_TRAP       = {4'd12, 10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Apply inputs for one cycle, check the outputs mid-cycle, then advance a clock.
    task automatic cyc(input logic mr, input logic [5:0] op, input logic [21:0] exp, input string tag);
        bus_if.mem_ready = mr;
        bus_if.opcode    = op;
        #1;
        chk(tag, {10'd0, obs}, {10'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_hold", {10'd0, obs}, {10'd0, E_RESET});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.mem_ready = 1'b1;
        bus_if.opcode    = OP_ADDI;
        do_reset();

        // addi x3: states 0,1,10,11
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, OP_ADDI, E_FETCH_RDY, "addi_fetch");
            cyc(1'b1, OP_ADDI, E_DECODE,    "addi_decode");
            cyc(1'b1, OP_ADDI, E_AEXEC,     "addi_exec");
            cyc(1'b1, OP_ADDI, E_AWB,       "addi_wb");
        end
`ifdef MCTRL_PERF_CNT_EN
        chk("perf_cycle",   cycle_cnt,   32'd12);
        chk("perf_retired", retired_cnt, 32'd3);
`endif

        // lw with two wait cycles in MEMRD
        cyc(1'b1, OP_LW, E_FETCH_RDY, "lw_fetch");
        cyc(1'b1, OP_LW, E_DECODE,    "lw_decode");
        cyc(1'b1, OP_LW, E_MEMADR,    "lw_memadr");
        cyc(1'b0, OP_LW, E_MEMRD,     "lw_memrd_w1");
        cyc(1'b0, OP_LW, E_MEMRD,     "lw_memrd_w2");
        cyc(1'b1, OP_LW, E_MEMRD,     "lw_memrd_rdy");
        cyc(1'b1, OP_LW, E_MEMWB,     "lw_memwb");

        // sw with one wait cycle
        cyc(1'b1, OP_SW, E_FETCH_RDY,  "sw_fetch");
        cyc(1'b1, OP_SW, E_DECODE,     "sw_decode");
        cyc(1'b1, OP_SW, E_MEMADR,     "sw_memadr");
        cyc(1'b0, OP_SW, E_MEMWR_WAIT, "sw_memwr_w");
        cyc(1'b1, OP_SW, E_MEMWR_RDY,  "sw_memwr_rdy");

        // beq after a stalled fetch
        cyc(1'b0, OP_BEQ, E_FETCH_WAIT, "beq_fetch_w");
        cyc(1'b1, OP_BEQ, E_FETCH_RDY,  "beq_fetch");
        cyc(1'b1, OP_BEQ, E_DECODE,     "beq_decode");
        cyc(1'b1, OP_BEQ, E_BRANCH,     "beq_branch");

        // j then R-type
        cyc(1'b1, OP_J, E_FETCH_RDY, "j_fetch");
        cyc(1'b1, OP_J, E_DECODE,    "j_decode");
        cyc(1'b1, OP_J, E_JUMP,      "j_jump");
        cyc(1'b1, OP_R, E_FETCH_RDY, "r_fetch");
        cyc(1'b1, OP_R, E_DECODE,    "r_decode");
        cyc(1'b1, OP_R, E_EXEC,      "r_exec");
        cyc(1'b1, OP_R, E_RWB,       "r_rwb");

        // illegal opcode traps and stays quiet regardless of mem_ready
        cyc(1'b1, OP_BAD, E_FETCH_RDY, "bad_fetch");
        cyc(1'b1, OP_BAD, E_DECODE,    "bad_decode");
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom_range(1, 0)), OP_BAD, E_TRAP, "bad_trap");
        end
        do_reset();

        // reset in the middle of a lw read wait
        cyc(1'b1, OP_LW, E_FETCH_RDY, "mid_fetch");
        cyc(1'b1, OP_LW, E_DECODE,    "mid_decode");
        cyc(1'b1, OP_LW, E_MEMADR,    "mid_memadr");
        reset = 1'b1;
        cyc(1'b1, OP_LW, E_MEMRD_RST, "mid_reset_gate");
        chk("mid_reset_state", {10'd0, obs}, {10'd0, E_RESET});
        reset = 1'b0;
        cyc(1'b1, OP_LW, E_FETCH_RDY, "mid_restart");

        // fetch timeout: 15 low cycles trap
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, OP_ADDI, E_FETCH_WAIT, "to_fetch_w");
        end
        chk("to_trap", {10'd0, obs}, {10'd0, E_TRAP});

        // ready on cycle 15 beats the timeout
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, OP_ADDI, E_FETCH_WAIT, "to2_fetch_w");
        end
        cyc(1'b1, OP_ADDI, E_FETCH_RDY, "to2_fetch_rdy");
        cyc(1'b1, OP_ADDI, E_DECODE,    "to2_decode");

        // counter clears on ready: two 14-cycle waits back to back do not trap
        cyc(1'b1, OP_ADDI, E_AEXEC, "to3_exec");
        cyc(1'b1, OP_ADDI, E_AWB,   "to3_wb");
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, OP_LW, E_FETCH_WAIT, "to3_fetch_w");
        end
        cyc(1'b1, OP_LW, E_FETCH_RDY, "to3_fetch_rdy");
        cyc(1'b1, OP_LW, E_DECODE,    "to3_decode");
        cyc(1'b1, OP_LW, E_MEMADR,    "to3_memadr");
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, OP_LW, E_MEMRD, "to3_memrd_w");
        end
        cyc(1'b1, OP_LW, E_MEMRD, "to3_memrd_rdy");
        cyc(1'b1, OP_LW, E_MEMWB, "to3_memwb");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences a multicycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers, one ALU.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq, j and addi.
- Takes the latched IR opcode and a memory-ready handshake.
- Drives every datapath mux select and write strobe, one instruction at a time.

Parameters:
- TIMEOUT, 15: max consecutive cycles waiting on mem_ready before trapping. 0 disables the timeout.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], stable from DECODE until the instruction completes
- mem_ready  in  1  memory has returned data or accepted the write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU Zero (datapath ANDs)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- MemtoReg  out  1  write-back select: 0=ALUOut, 1=MDR
- RegDST  out  1  write-back register: 0=rt, 1=rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A input: 0=PC, 1=A
- ALUSrcB  out  2  ALU B input: 00=B, 01=4, 10=signext, 11=signext<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded
- PCSource  out  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}
- state  out  4  current state encoding, for debug
- instr_done  out  1  one-cycle pulse in an instruction's last state
- trap  out  1  sticky; set on illegal opcode or timeout

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7
  - BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=12
  - 13-15 are unreachable; decode them as TRAP.
- Reset:
  - Edge with reset=1 loads state=FETCH, clears trap and the wait counter.
  - While reset=1, all strobes are forced to 0 (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done).
- Default: every output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite = mem_ready (Mealy).
  - Stay while !mem_ready; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes branch target). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - else -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD if opcode=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDST=0, instr_done=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1, held for the whole wait.
  - instr_done = mem_ready.
  - Go to FETCH when mem_ready=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegWrite=1, RegDST=1, MemtoReg=0, instr_done=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDI_WB.
- ADDI_WB: RegWrite=1, RegDST=0, MemtoReg=0, instr_done=1. Next FETCH.
- TRAP: all strobes 0, trap=1. Absorbing until reset.
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with mem_ready still 0, next state is TRAP.
  - mem_ready=1 in that same cycle wins: normal transition.
- Latency in cycles with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each memory wait adds one cycle per low mem_ready cycle.
- Reset mid-instruction: the abandoned instruction has no further strobes; the controller restarts at FETCH.

Optional Feature:
- Macro: MCTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt [CNT_W-1:0] and retired_cnt [CNT_W-1:0].
  - cycle_cnt increments every non-reset cycle while not in TRAP.
  - retired_cnt increments on each instr_done.
  - Both clear on reset and wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, mem_ready=1, opcode=001000 (addi) -> states 0,1,10,11,0. RegWrite=1 only in ADDI_WB. instr_done pulses once, 4 cycles after reset release.
- opcode=100011 (lw), mem_ready low for 2 cycles in MEMRD -> MemRead and IorD held 3 cycles. Then MEMWB with RegWrite=1, MemtoReg=1. Total 7 cycles.
- opcode=000100 (beq) -> BRANCH with PCWriteCond=1, PCSource=01, ALUOp=01. Back to FETCH after 3 cycles. PCWrite never 1 outside FETCH.
- opcode=000010 (j) -> JUMP with PCWrite=1, PCSource=10. Next opcode=000000 -> EXEC with ALUOp=10, then RWB with RegDST=1.
- opcode=111111 -> TRAP after DECODE, trap=1, all strobes 0 for 20 cycles. Reset -> trap=0, state=0.
- TIMEOUT=15, mem_ready=0 in FETCH -> state=TRAP after exactly 15 cycles. Repeat with mem_ready rising on cycle 15 -> DECODE, no trap. With MCTRL_PERF_CNT_EN, after 3 addi retirements: retired_cnt=3, cycle_cnt=12.
